// File: rtl/traffic_char_ctrl_if.sv
// Overlay control bundle: frame sync and enable in, glyph indices and status out.
interface traffic_char_ctrl_if;
  logic       vsync_i;
  logic       run_en;
  logic [7:0] char_0;
  logic [7:0] char_1;
  logic [7:0] char_2;
  logic [1:0] light_st;
  logic       flag_green;
  logic       phase_done;

  // Driver side (video timing / system control)
  modport master (
    output vsync_i, run_en,
    input  char_0, char_1, char_2, light_st, flag_green, phase_done
  );

  // Controller side
  modport slave (
    input  vsync_i, run_en,
    output char_0, char_1, char_2, light_st, flag_green, phase_done
  );
endinterface

// File: rtl/traffic_char_ctrl.sv
// Traffic-light countdown scheduler feeding glyph indices to a character overlay.
// RED -> GREEN -> RED phases advance on a per-second tick; a two-digit BCD
// countdown is kept internally and published only on the falling edge of vsync_i.
// Optional macro GREEN_HIDE_CNT_EN: hide the digits (glyph 15) while GREEN is published.
module traffic_char_ctrl #(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned RED_SEC     = 30,
  parameter int unsigned GREEN_SEC   = 20
) (
  input logic                clk,
  input logic                rst_n,
  traffic_char_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_CYCLES);

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

  localparam logic [3:0] RED_TENS   = 4'(RED_SEC / 10);
  localparam logic [3:0] RED_ONES   = 4'(RED_SEC % 10);
  localparam logic [3:0] GREEN_TENS = 4'(GREEN_SEC / 10);
  localparam logic [3:0] GREEN_ONES = 4'(GREEN_SEC % 10);

  localparam logic [7:0] GLYPH_RED   = 8'd10;
  localparam logic [7:0] GLYPH_GREEN = 8'd11;
  localparam logic [7:0] GLYPH_NONE  = 8'd15;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_RED   = 2'd1;
  localparam logic [1:0] ST_GREEN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          phase_done_d;
  logic          vs_d;
  logic          fall;
  logic          tick;
  logic          bcd_is_one;
  logic [7:0]    pub_c0, pub_c1, pub_c2;

  assign fall       = vs_d & ~bus.vsync_i;
  assign tick       = (state_q != ST_OFF) && (presc_q == TICK_LAST);
  assign bcd_is_one = (tens_q == 4'd0) && (ones_q == 4'd1);

  // State, prescaler, countdown and phase_done registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_OFF;
      presc_q        <= '0;
      tens_q         <= 4'd0;
      ones_q         <= 4'd0;
      bus.phase_done <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      tens_q         <= tens_d;
      ones_q         <= ones_d;
      bus.phase_done <= phase_done_d;
    end
  end

  // Next-state: enable handling, prescaler, BCD countdown and phase switching
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    tens_d       = tens_q;
    ones_d       = ones_q;
    phase_done_d = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (bus.run_en) begin
          state_d = ST_RED;
          tens_d  = RED_TENS;
          ones_d  = RED_ONES;
          presc_d = '0;
        end
      end
      ST_RED, ST_GREEN: begin
        if (!bus.run_en) begin
          // Disable wins over a coincident tick
          state_d = ST_OFF;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          presc_d = '0;
        end else if (tick) begin
          presc_d = '0;
          if (bcd_is_one) begin
            // Switch instead of showing 00
            phase_done_d = 1'b1;
            if (state_q == ST_RED) begin
              state_d = ST_GREEN;
              tens_d  = GREEN_TENS;
              ones_d  = GREEN_ONES;
            end else begin
              state_d = ST_RED;
              tens_d  = RED_TENS;
              ones_d  = RED_ONES;
            end
          end else if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        tens_d  = 4'd0;
        ones_d  = 4'd0;
        presc_d = '0;
      end
    endcase
  end

  // Glyph mapping of the current (pre-update) internal state
  always_comb begin
    pub_c0 = GLYPH_NONE;
    pub_c1 = 8'd0;
    pub_c2 = 8'd0;
    case (state_q)
      ST_RED: begin
        pub_c0 = GLYPH_RED;
        pub_c1 = {4'd0, tens_q};
        pub_c2 = {4'd0, ones_q};
      end
      ST_GREEN: begin
        pub_c0 = GLYPH_GREEN;
`ifdef GREEN_HIDE_CNT_EN
        pub_c1 = GLYPH_NONE;
        pub_c2 = GLYPH_NONE;
`else
        pub_c1 = {4'd0, tens_q};
        pub_c2 = {4'd0, ones_q};
`endif
      end
      default: begin
        pub_c0 = GLYPH_NONE;
      end
    endcase
  end

  // Frame-synchronous publish on the falling edge of vsync_i
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_d           <= 1'b0;
      bus.char_0     <= GLYPH_NONE;
      bus.char_1     <= 8'd0;
      bus.char_2     <= 8'd0;
      bus.light_st   <= ST_OFF;
      bus.flag_green <= 1'b0;
    end else begin
      vs_d <= bus.vsync_i;
      if (fall) begin
        bus.char_0     <= pub_c0;
        bus.char_1     <= pub_c1;
        bus.char_2     <= pub_c2;
        bus.light_st   <= state_q;
        bus.flag_green <= (state_q == ST_GREEN);
      end
    end
  end

endmodule

// File: tb/tb_traffic_char_ctrl.sv
// Randomized scoreboard bench for traffic_char_ctrl (TICK_CYCLES=4, RED_SEC=12, GREEN_SEC=2).
module tb_traffic_char_ctrl;

  localparam int unsigned TICK  = 4;
  localparam int unsigned RED   = 12;
  localparam int unsigned GREEN = 2;

  typedef struct packed {
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
    logic [1:0] ls;
    logic       fg;
    logic       pd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  exp_t sb_q[$];

  traffic_char_ctrl_if bus();

  traffic_char_ctrl #(
    .TICK_CYCLES(TICK),
    .RED_SEC    (RED),
    .GREEN_SEC  (GREEN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyph view of a phase (0=OFF,1=RED,2=GREEN) with `left` seconds remaining
  function automatic exp_t publish(input int st, input int left, input logic pd);
    exp_t e;
    e.pd = pd;
    e.ls = 2'(st);
    e.fg = (st == 2);
    if (st == 0) begin
      e.c0 = 8'd15; e.c1 = 8'd0; e.c2 = 8'd0;
    end else begin
      e.c0 = (st == 1) ? 8'd10 : 8'd11;
      e.c1 = 8'(left / 10);
      e.c2 = 8'(left % 10);
`ifdef GREEN_HIDE_CNT_EN
      if (st == 2) begin
        e.c1 = 8'd15; e.c2 = 8'd15;
      end
`endif
    end
    return e;
  endfunction

  // Reference model: phase + whole seconds remaining + cycles into current second
  initial begin
    int   m_st;
    int   m_left;
    int   m_sub;
    logic m_vs;
    exp_t p;
    m_st = 0; m_left = 0; m_sub = 0; m_vs = 1'b0;
    p = publish(0, 0, 1'b0);
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_st = 0; m_left = 0; m_sub = 0; m_vs = 1'b0;
        p = publish(0, 0, 1'b0);
      end else begin
        p.pd = 1'b0;
        if (m_vs && !bus.vsync_i) p = publish(m_st, m_left, 1'b0);
        if (m_st == 0) begin
          if (bus.run_en) begin
            m_st = 1; m_left = RED; m_sub = 0;
          end
        end else if (!bus.run_en) begin
          m_st = 0; m_left = 0; m_sub = 0;
        end else if (m_sub == TICK - 1) begin
          m_sub = 0;
          if (m_left == 1) begin
            m_st   = (m_st == 1) ? 2 : 1;
            m_left = (m_st == 1) ? RED : GREEN;
            p.pd   = 1'b1;
          end else begin
            m_left = m_left - 1;
          end
        end else begin
          m_sub = m_sub + 1;
        end
        m_vs = bus.vsync_i;
      end
      sb_q.push_back(p);
    end
  end

  // Monitor: every cycle the DUT presents its registered outputs; pop and compare
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = '{bus.char_0, bus.char_1, bus.char_2, bus.light_st, bus.flag_green, bus.phase_done};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d got c0=%0d c1=%0d c2=%0d st=%0d fg=%0d pd=%0d exp c0=%0d c1=%0d c2=%0d st=%0d fg=%0d pd=%0d",
                   cyc, a.c0, a.c1, a.c2, a.ls, a.fg, a.pd, e.c0, e.c1, e.c2, e.ls, e.fg, e.pd);
        end
      end
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the active edge
  task automatic step(input logic rn, input logic re, input logic vs);
    rst_n       = rn;
    bus.run_en  = re;
    bus.vsync_i = vs;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic vs;
    logic re;
    int   vs_cnt;
    int   vs_per;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; bus.run_en = 1'b0; bus.vsync_i = 1'b0;
    vs = 1'b0; re = 1'b0; vs_cnt = 3;

    // Reset held with vsync toggling
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, vs);
      if (--vs_cnt == 0) begin vs = ~vs; vs_cnt = 3; end
    end

    // Run through RED -> GREEN -> RED with vsync every 3 clocks
    for (int i = 0; i < 160; i++) begin
      step(1'b1, 1'b1, vs);
      if (--vs_cnt == 0) begin vs = ~vs; vs_cnt = 3; end
    end

    // Drop enable briefly, then restart
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, vs);
      if (--vs_cnt == 0) begin vs = ~vs; vs_cnt = 3; end
    end

    // vsync held high for 20 clocks across ticks, then falls
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)  step(1'b1, 1'b1, 1'b0);

    // Randomized: enable toggling, irregular frame timing, occasional reset
    re = 1'b1; vs = 1'b1; vs_per = 3; vs_cnt = 3;
    for (int i = 0; i < 4000; i++) begin
      if (re ? ($urandom_range(0, 119) == 0) : ($urandom_range(0, 9) == 0)) re = ~re;
      if ($urandom_range(0, 599) == 0) begin
        step(1'b0, re, vs);
      end else begin
        step(1'b1, re, vs);
      end
      if (--vs_cnt == 0) begin
        vs = ~vs;
        vs_per = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 6));
        vs_cnt = vs_per;
      end
    end

    step(1'b1, re, vs);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb_q.size() > 1) begin
      bad++;
      $display("FAIL drain got %0d pending exp at most 1", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
